// File: rtl/button_press_fsm_if.sv
// Button classifier signal bundle: debounced level in, press pulses and level out.
// master = debouncer/stimulus side, slave = classifier side.
interface button_press_fsm_if;
  logic pb_debounced;
  logic short_press;
  logic long_press;
  logic repeat_press;
  logic pressed;

  modport master (
    output pb_debounced,
    input  short_press, long_press, repeat_press, pressed
  );

  modport slave (
    input  pb_debounced,
    output short_press, long_press, repeat_press, pressed
  );
endinterface

// File: rtl/button_press_fsm.sv
// Short/long press classifier with optional auto-repeat while held.
// Define BTN_REPEAT_EN to compile in the repeat_press generator.
module button_press_fsm #(
  parameter int LONG_CYCLES   = 100,
  parameter int REPEAT_CYCLES = 25,
  parameter int CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  button_press_fsm_if.slave  btn
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRESS = 2'd1;
  localparam logic [1:0] ST_HELD  = 2'd2;

  localparam int MAX_CYC = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 1 || (MAX_CYC - 1) >= (2 ** CNT_W)) begin : g_bad_params
    $error("button_press_fsm: illegal LONG_CYCLES/REPEAT_CYCLES/CNT_W combination");
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             pressed_q, pressed_d;
  logic             rep_d;

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic rep_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn.pb_debounced) begin
          state_d = ST_PRESS;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      ST_PRESS: begin
        // release is checked first so a press ending on the long threshold is still short
        if (!btn.pb_debounced) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = ST_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (!btn.pb_debounced) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
`ifdef BTN_REPEAT_EN
          if (cnt_q == REP_LAST) begin
            rep_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`else
          cnt_d = '0;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    pressed_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      short_q   <= short_d;
      long_q    <= long_d;
      pressed_q <= pressed_d;
    end
  end

`ifdef BTN_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_q <= 1'b0;
    else        rep_q <= rep_d;
  end
  assign btn.repeat_press = rep_q;
`else
  logic unused_rep;
  assign unused_rep       = rep_d;
  assign btn.repeat_press = 1'b0;
`endif

  assign btn.short_press = short_q;
  assign btn.long_press  = long_q;
  assign btn.pressed     = pressed_q;

endmodule

// File: doc/button_press_fsm.md
# button_press_fsm

Classifies presses on a debounced push-button level as short or long. Emits one-cycle pulses that drive the lab's control logic, such as mode select and counter start/stop. It sits directly downstream of the push-button debouncer and takes its `pb_debounced` output. Both blocks run on the same slow sampling clock.

## Interface
Parameters:
- `LONG_CYCLES`, default 100: number of consecutive high samples that qualify a press as long. Must be ≥ 2.
- `REPEAT_CYCLES`, default 25: auto-repeat period in cycles while the button is held after a long press. Must be ≥ 1. Used only when `BTN_REPEAT_EN` is defined.
- `CNT_W`, default 8: hold counter width. Must hold `max(LONG_CYCLES, REPEAT_CYCLES) - 1`.

Ports:
- `clk` input 1: single clock, the same clock as the debouncer.
- `rst_n` input 1: reset, asynchronous and active-low.
- `pb_debounced` input 1: debounced button level. Already synchronous to `clk`; used without a further register.
- `short_press` output 1: one-cycle pulse; the button was released before qualifying as long.
- `long_press` output 1: one-cycle pulse; the button was held for `LONG_CYCLES` samples.
- `repeat_press` output 1: one-cycle pulse every `REPEAT_CYCLES` while held past long. Tied to 0 without the macro.
- `pressed` output 1: registered level, high while the FSM is not in IDLE.

## Operation
- States: IDLE, PRESS, HELD. The state register, `cnt[CNT_W-1:0]` and all outputs are registered.
- Reset: state = IDLE, `cnt` = 0, `short_press` = `long_press` = `repeat_press` = `pressed` = 0.
- IDLE:
  - `pb_debounced` = 1 → PRESS, `cnt` ← 1.
  - Otherwise stay in IDLE, `cnt` ← 0.
- PRESS: the release check has priority.
  - `pb_debounced` = 0 → `short_press` ← 1, go to IDLE, `cnt` ← 0.
  - Else if `cnt` == `LONG_CYCLES - 1` → `long_press` ← 1, go to HELD, `cnt` ← 0.
  - Else `cnt` ← `cnt + 1`.
- HELD:
  - `pb_debounced` = 0 → IDLE, `cnt` ← 0. A release after a long press produces no pulse.
  - Else, with the macro defined: if `cnt` == `REPEAT_CYCLES - 1`, then `repeat_press` ← 1 and `cnt` ← 0; otherwise `cnt` ← `cnt + 1`.
  - Else, without the macro: `cnt` holds at 0.
- Pulse outputs default to 0 every cycle. At most one of `short_press`, `long_press`, `repeat_press` is high in any cycle.
- `pressed` ← 1 when the next state is PRESS or HELD; otherwise 0.
- A button held through reset release is seen as a new press: IDLE samples 1 and moves to PRESS.
- The counter never wraps. The compare thresholds bound it below `2^CNT_W`.

## Timing
- Number the sampling edges from edge 1, the first edge that samples `pb_debounced` = 1. Sample N is taken at edge N.
- Short press:
  - A press of N high samples, with 1 ≤ N ≤ `LONG_CYCLES - 1`, is followed by a low sample at edge N+1.
  - `short_press` is high in the cycle after edge N+1.
- Long press: `long_press` is high in the cycle after edge `LONG_CYCLES`.
- Repeat: `repeat_press` is high in the cycles after edges `LONG_CYCLES + k*REPEAT_CYCLES`, for k ≥ 1, while the button stays high.
- `pressed`: rises in the cycle after edge 1. Falls in the cycle after the first low sample.
- Latency: one clock from the deciding sample to the pulse. No combinational path from input to output.
- Reset asserted mid-press: all outputs go to 0 immediately (asynchronous). No pulse is emitted for the aborted press.
- Release sampled on the same edge a repeat would be due: release wins, no `repeat_press`.

## Configuration
- `BTN_REPEAT_EN` defined:
  - HELD counts cycles and emits `repeat_press` every `REPEAT_CYCLES`.
  - The repeat compare logic is compiled in.
- `BTN_REPEAT_EN` undefined:
  - The `repeat_press` port still exists and is driven constant 0.
  - The `cnt` logic in HELD is removed.
  - `REPEAT_CYCLES` is ignored.

## Test plan
All scenarios use `LONG_CYCLES` = 8, `REPEAT_CYCLES` = 4, `CNT_W` = 4.
- Press 3 samples high, then low → `short_press` = 1 for one cycle after edge 4; `long_press` stays 0; `pressed` is high for 3 cycles.
- Press 1 sample high, then 7 samples high in a separate press → `short_press` pulses after each release; `long_press` never fires.
- Press held 8 samples → `long_press` = 1 for one cycle after edge 8. Continue holding to sample 25, then release:
  - Macro off: no further pulses.
  - Macro on: `repeat_press` pulses after edges 12, 16, 20, 24.
  - Both cases: no pulse on release.
- Macro on, release sampled at edge 16 → no `repeat_press` at 16; state goes to IDLE; `pressed` = 0.
- Assert `rst_n` = 0 after sample 5 of a press, then release reset with the input low → all outputs 0 throughout; no `short_press` or `long_press` is emitted.
- Release reset with `pb_debounced` = 1 held for 2 samples, then low → `pressed` rises after edge 1; `short_press` pulses after edge 3.
